// File: rtl/regfile_wb_queue_pkg.sv
// regfile_wb_queue_pkg: LC-3b shared types plus the write-back queue entry and default depth.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef struct packed {
        lc3b_reg  dest;
        lc3b_word data;
    } lc3b_wb_entry;
    localparam int WBQ_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/regfile_wb_queue_fwd_match.sv
// wbq_fwd_match: finds the youngest occupied queue entry whose dest matches src.
module wbq_fwd_match
    import lc3b_types::*;
#(
    parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
    input  lc3b_wb_entry             entries [DEPTH],
    input  logic [DEPTH-1:0]         valid,
    input  logic [$clog2(DEPTH)-1:0] head,
    input  lc3b_reg                  src,
    output logic                     hit,
    output lc3b_word                 data
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] idx;
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (valid[idx] && entries[idx].dest == src) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of pending register-file writes, drained one per cycle.
// Define REGFILE_WBQ_FWD_EN to enable forwarding of queued values to decode.
module regfile_wb_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  lc3b_reg                wr_dest,
    input  lc3b_word               wr_data,
    input  logic                   hold,
    output logic                   load,
    output lc3b_reg                dest,
    output lc3b_word               in,
    input  lc3b_reg                src_a,
    input  lc3b_reg                src_b,
    output logic                   fwd_a_hit,
    output logic                   fwd_b_hit,
    output lc3b_word               fwd_a_data,
    output lc3b_word               fwd_b_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    lc3b_wb_entry  mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push;
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign wr_ready = !full;
    assign load     = !empty && !hold;
    assign push     = wr_valid && wr_ready;
    assign dest     = empty ? '0 : mem[head].dest;
    assign in       = empty ? '0 : mem[head].data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (load) head <= head + AW'(1);
            count <= count + CW'(push) - CW'(load);
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[tail] <= '{dest: wr_dest, data: wr_data};
    end
`ifdef REGFILE_WBQ_FWD_EN
    logic [DEPTH-1:0] valid;
    // An entry is occupied when its distance from head is below count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, AW'(AW'(i) - head)} < count;
    end
    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .entries(mem), .valid(valid), .head(head), .src(src_a),
        .hit(fwd_a_hit), .data(fwd_a_data)
    );
    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .entries(mem), .valid(valid), .head(head), .src(src_b),
        .hit(fwd_b_hit), .data(fwd_b_data)
    );
`else
    logic unused_src;
    assign unused_src = ^{src_a, src_b};
    assign fwd_a_hit  = 1'b0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed vector table plus randomized run against a queue model.
module tb_regfile_wb_queue;
    import lc3b_types::*;
    localparam int DEPTH = 4;
`ifdef REGFILE_WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n, wr_valid, wr_ready, hold, load, fwd_a_hit, fwd_b_hit, empty, full;
    lc3b_reg wr_dest, dest, src_a, src_b;
    lc3b_word wr_data, in, fwd_a_data, fwd_b_data;
    logic [2:0] count;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_dest(wr_dest), .wr_data(wr_data), .hold(hold), .load(load),
        .dest(dest), .in(in), .src_a(src_a), .src_b(src_b),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .count(count), .empty(empty), .full(full)
    );
    typedef struct {
        bit rst_n, wv, hold;
        logic [2:0] wd;
        logic [15:0] wdat;
        logic [2:0] sa, sb;
        bit fchk;
        int cnt;
        bit ld;
        logic [2:0] d;
        logic [15:0] dat;
        bit fah;
        logic [15:0] fad;
        bit fbh;
    } vec_t;
    vec_t tv [26];
    lc3b_wb_entry q [$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic vec_t mk(bit r, bit wv, bit h, logic [2:0] wd, logic [15:0] wdat,
                                int cnt, bit ld, logic [2:0] d, logic [15:0] dat);
        vec_t v;
        v = '{rst_n: r, wv: wv, hold: h, wd: wd, wdat: wdat, sa: 3'd0, sb: 3'd0, fchk: 1'b0,
              cnt: cnt, ld: ld, d: d, dat: dat, fah: 1'b0, fad: 16'h0, fbh: 1'b0};
        return v;
    endfunction
    task automatic drive(bit r, bit wv, bit h, logic [2:0] wd, logic [15:0] wdat,
                         logic [2:0] sa, logic [2:0] sb);
        rst_n = r; wr_valid = wv; hold = h; wr_dest = wd; wr_data = wdat; src_a = sa; src_b = sb;
    endtask
    task automatic chk_fwd(string tag, bit ah, logic [15:0] ad, bit bh, logic [15:0] bd);
        chk({tag, " fwd_a_hit"}, 32'(fwd_a_hit), 32'(FWD & ah));
        if (ah || !FWD) chk({tag, " fwd_a_data"}, 32'(fwd_a_data), FWD ? 32'(ad) : 32'h0);
        chk({tag, " fwd_b_hit"}, 32'(fwd_b_hit), 32'(FWD & bh));
        if (bh || !FWD) chk({tag, " fwd_b_data"}, 32'(fwd_b_data), FWD ? 32'(bd) : 32'h0);
    endtask
    function automatic bit model_hit(lc3b_reg s, output lc3b_word v);
        v = '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].dest == s) begin
                v = q[i].data;
                return 1'b1;
            end
        return 1'b0;
    endfunction
    initial begin
        bit exp_ld, ah, bh;
        lc3b_word ad, bd;
        string tag;
        tv[0]  = mk(1,0,0,0,16'h0000, 0,0,0,16'h0000);
        tv[1]  = mk(1,1,0,3,16'h1234, 0,0,0,16'h0000);
        tv[2]  = mk(1,0,0,0,16'h0000, 1,1,3,16'h1234);
        tv[3]  = mk(1,1,1,0,16'h1000, 0,0,0,16'h0000);
        tv[4]  = mk(1,1,1,1,16'h1001, 1,0,0,16'h1000);
        tv[5]  = mk(1,1,1,2,16'h1002, 2,0,0,16'h1000);
        tv[6]  = mk(1,1,1,3,16'h1003, 3,0,0,16'h1000);
        tv[7]  = mk(1,1,1,4,16'h1004, 4,0,0,16'h1000);
        tv[8]  = mk(1,1,0,4,16'h1004, 4,1,0,16'h1000);
        tv[9]  = mk(1,0,0,0,16'h0000, 3,1,1,16'h1001);
        tv[10] = mk(1,1,0,5,16'h2000, 2,1,2,16'h1002);
        tv[11] = mk(1,1,0,6,16'h2001, 2,1,3,16'h1003);
        tv[12] = mk(1,0,0,0,16'h0000, 2,1,5,16'h2000);
        tv[13] = mk(1,0,0,0,16'h0000, 1,1,6,16'h2001);
        tv[14] = mk(1,1,1,5,16'h0001, 0,0,0,16'h0000);
        tv[15] = mk(1,1,1,5,16'h0002, 1,0,5,16'h0001);
        tv[16] = mk(1,0,1,0,16'h0000, 2,0,5,16'h0001);
        tv[17] = mk(1,0,0,0,16'h0000, 2,1,5,16'h0001);
        tv[18] = mk(1,0,0,0,16'h0000, 1,1,5,16'h0002);
        tv[19] = mk(1,0,0,0,16'h0000, 0,0,0,16'h0000);
        tv[20] = mk(1,1,1,1,16'h3001, 0,0,0,16'h0000);
        tv[21] = mk(1,1,1,2,16'h3002, 1,0,1,16'h3001);
        tv[22] = mk(1,1,1,3,16'h3003, 2,0,1,16'h3001);
        tv[23] = mk(0,1,1,4,16'h3004, 3,0,1,16'h3001);
        tv[24] = mk(1,0,0,0,16'h0000, 0,0,0,16'h0000);
        tv[25] = mk(1,0,0,0,16'h0000, 0,0,0,16'h0000);
        // Forwarding window: two R5 writes queued, R6 never present.
        for (int i = 15; i <= 19; i++) begin
            tv[i].sa = 3'd5; tv[i].sb = 3'd6; tv[i].fchk = 1'b1;
        end
        tv[15].fah = 1'b1; tv[15].fad = 16'h0001;
        for (int i = 16; i <= 18; i++) begin
            tv[i].fah = 1'b1; tv[i].fad = 16'h0002;
        end
        drive(0, 1, 0, 3'd7, 16'hdead, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 26; i++) begin
            drive(tv[i].rst_n, tv[i].wv, tv[i].hold, tv[i].wd, tv[i].wdat, tv[i].sa, tv[i].sb);
            @(negedge clk);
            tag = $sformatf("vec%0d", i);
            chk({tag, " count"}, 32'(count), 32'(tv[i].cnt));
            chk({tag, " load"}, 32'(load), 32'(tv[i].ld));
            chk({tag, " dest"}, 32'(dest), 32'(tv[i].d));
            chk({tag, " in"}, 32'(in), 32'(tv[i].dat));
            chk({tag, " empty"}, 32'(empty), 32'(tv[i].cnt == 0));
            chk({tag, " full"}, 32'(full), 32'(tv[i].cnt == DEPTH));
            chk({tag, " wr_ready"}, 32'(wr_ready), 32'(tv[i].cnt != DEPTH));
            if (tv[i].fchk) chk_fwd(tag, tv[i].fah, tv[i].fad, 1'b0, 16'h0);
            @(posedge clk);
            #1;
        end
        q.delete();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 29) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
            @(negedge clk);
            tag = $sformatf("rnd%0d", c);
            exp_ld = q.size() > 0 && !hold;
            chk({tag, " count"}, 32'(count), 32'(q.size()));
            chk({tag, " load"}, 32'(load), 32'(exp_ld));
            chk({tag, " dest"}, 32'(dest), q.size() > 0 ? 32'(q[0].dest) : 32'h0);
            chk({tag, " in"}, 32'(in), q.size() > 0 ? 32'(q[0].data) : 32'h0);
            chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
            chk({tag, " wr_ready"}, 32'(wr_ready), 32'(q.size() < DEPTH));
            ah = model_hit(src_a, ad);
            bh = model_hit(src_b, bd);
            chk_fwd(tag, ah, ad, bh, bd);
            @(posedge clk);
            if (!rst_n) q.delete();
            else begin
                bit acc;
                acc = wr_valid && q.size() < DEPTH;
                if (exp_ld) void'(q.pop_front());
                if (acc) q.push_back('{dest: wr_dest, data: wr_data});
            end
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue directly upstream of the 8×16 LC-3b register file. Execution/memory stages push (dest, data) write requests through a valid/ready handshake. The queue drains at most one entry per cycle into the register file's `load`/`dest`/`in` write port. An optional forwarding path lets the decode stage see values that are still queued and not yet written.

## Interface
- `DEPTH`, 4: number of queued writes; power of two, ≥ 2.
- `clk`  in  1  rising-edge clock, shared with the register file.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_valid`  in  1  producer has a write request.
- `wr_ready`  out  1  queue can accept; equals `!full`.
- `wr_dest`  in  3 (`lc3b_reg`)  destination register of the request.
- `wr_data`  in  16 (`lc3b_word`)  write data.
- `hold`  in  1  suppresses draining this cycle.
- `load`  out  1  register-file write enable.
- `dest`  out  3 (`lc3b_reg`)  register-file write address.
- `in`  out  16 (`lc3b_word`)  register-file write data.
- `src_a`, `src_b`  in  3 each  decode-stage read addresses, for forwarding.
- `fwd_a_hit`, `fwd_b_hit`  out  1 each  a queued entry matches `src_a`/`src_b`.
- `fwd_a_data`, `fwd_b_data`  out  16 each  forwarded value.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `empty`, `full`  out  1 each  occupancy flags.

## Operation
- Circular buffer: `head` pointer, `tail` pointer, registered `count`. Pointers wrap modulo DEPTH.
- **Enqueue:**
  - Fires when `wr_valid && wr_ready`.
  - Writes `{wr_dest, wr_data}` at `tail`, then advances `tail`.
- **Dequeue:**
  - `load = !empty && !hold`, combinational.
  - `dest`/`in` show the head entry when `!empty`, and 0 when empty.
  - Dequeue fires when `load` is 1; `head` advances on that edge.
- **Simultaneous enqueue and dequeue:** `count` is unchanged and both pointers advance.
- **Full:** `wr_ready` = 0. A dequeue in the same cycle does not make room until the next cycle (no pass-through).
- **Empty:** no bypass of the incoming request to `load`. An accepted request always spends at least one cycle in the queue.
- **Ordering:** strict FIFO. Two entries with the same `dest` are both written, oldest first.
- **Reset:**
  - `rst_n` = 0 at a rising edge clears `head`, `tail` and `count`.
  - Outputs then read `load`=0, `dest`=0, `in`=0, `empty`=1, `full`=0, `wr_ready`=1, all forwarding outputs 0.
  - Entry contents are don't-care.
  - Reset mid-operation discards queued writes; none reach the register file.
  - `wr_valid` during a reset cycle is ignored.

## Timing
- Request accepted at edge N: `load` asserts in cycle N+1 if `!hold`. The register file holds the value after edge N+1.
- Throughput: one enqueue and one dequeue per cycle.
- `wr_ready`, `load`, `dest`, `in`, `empty`, `full` and `count` depend only on registered state, plus `hold` for `load`.
- Forwarding outputs are combinational from `src_a`/`src_b` and registered entries.

## Configuration
- `REGFILE_WBQ_FWD_EN` defined:
  - `fwd_x_hit` = 1 when any occupied entry has `dest == src_x`.
  - `fwd_x_data` is the youngest matching entry's data.
  - The entry being dequeued this cycle still counts as occupied.
  - The request being enqueued this cycle is not visible.
- Macro undefined:
  - The forwarding outputs are tied to 0.
  - No comparators are synthesised.
  - The ports remain present.

## Structure
- Package `lc3b_types` gains:
  - `lc3b_wb_entry` (packed struct `{lc3b_reg dest; lc3b_word data;}`).
  - `WBQ_DEPTH_DEFAULT = 4`.
- Existing `lc3b_word`/`lc3b_reg` are reused.
- Sub-module `wbq_fwd_match`: one instance per read port. It takes the entry array, valid mask, head pointer and src, and returns the youngest match as hit and data. It is instantiated only under `REGFILE_WBQ_FWD_EN`.

## Test plan
- **Reset:** hold `rst_n`=0 two cycles with `wr_valid`=1 → `count`=0, `load`=0, `wr_ready`=1; no register-file write.
- **Single write:** push (R3, 0x1234) at edge N → `load`=1, `dest`=3, `in`=0x1234 in cycle N+1; `empty`=1 after edge N+1.
- **Fill under hold:** `hold`=1, push 4 entries → `full`=1, `wr_ready`=0 and a 5th push is refused. Release `hold` → drain order is preserved, one entry per cycle.
- **Simultaneous push and pop:** at `count`=2, `count` stays 2 and the pointer wraps past DEPTH-1 correctly.
- **Forwarding (macro on):**
  - Queue (R5,0x0001) then (R5,0x0002), `src_a`=5 → `fwd_a_hit`=1, `fwd_a_data`=0x0002.
  - `src_b`=6 → `fwd_b_hit`=0.
  - Macro off → both hits 0.
- **Mid-operation reset:** 3 entries queued, `rst_n`=0 for one edge → no further `load`, `count`=0.
